instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 183 ++++++++++++++++++
 tb/tb_instr_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Streams a program into instruction memory from an 8-bit upstream byte
// channel, then releases the CPU from reset.
//
// A start pulse (in IDLE or DONE) latches a word count. That count is
// clipped to DEPTH. Bytes are packed big-endian into 32-bit words. Each
// completed word is written to memory with a single-cycle strobe. After
// the last word the block parks in DONE with the CPU released.
//
// Ports
//   clk_i         sole clock, rising edge
//   rst_i         asynchronous, active-low reset
//   start_i       load request pulse (honoured in IDLE and DONE only)
//   len_i         number of words to load, sampled with start_i
//   byte_valid_i  upstream byte valid
//   byte_data_i   upstream byte
//   byte_ready_o  byte accepted this cycle if byte_valid_i is also high
//   mem_we_o      instruction-memory write strobe
//   mem_addr_o    word-aligned byte address of the write
//   mem_data_o    word to write
//   cpu_rst_o     active-low CPU reset (1 = CPU released)
//   busy_o        load in progress
//   done_o        last load completed
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int DEPTH = 32,
  parameter int LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             cpu_rst_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [1:0]         byte_cnt_reg;
  logic [IDX_W-1:0]   word_idx_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [31:0]        word_reg;
  logic [31:0]        mem_addr_reg;
  logic [31:0]        mem_data_reg;

  logic               start_accept;
  logic               byte_fire;
  logic               last_word;
  logic [LEN_W-1:0]   len_clipped;

  // byte_ready_o depends only on state, so a transfer is just "RECV and valid".
  assign byte_fire    = (state_reg == RECV) && byte_valid_i;
  assign start_accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));
  assign len_clipped  = (len_i > DEPTH_L) ? DEPTH_L : len_i;

  // len_reg is never 0 while a load is running, so len_reg-1 cannot underflow
  // in WRITE. Because len_reg <= DEPTH, word_idx stays below DEPTH.
  assign last_word    = (LEN_W'(word_idx_reg) == (len_reg - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          state_next = (len_i == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (byte_fire && (byte_cnt_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_word ? DONE : RECV;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, decoded from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    cpu_rst_o    = 1'b0;
    case (state_reg)
      RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      WRITE: begin
        mem_we_o = 1'b1;
        busy_o   = 1'b1;
      end
      DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr_o = mem_addr_reg;
  assign mem_data_o = mem_data_reg;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_cnt_reg <= '0;
      word_idx_reg <= '0;
      len_reg      <= '0;
      word_reg     <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else begin
      if (start_accept) begin
        byte_cnt_reg <= '0;
        word_idx_reg <= '0;
        if (len_i != '0) begin
          len_reg <= len_clipped;
        end
      end

      if (byte_fire) begin
        // Shifting left makes the first byte of a word end up in [31:24].
        word_reg     <= {word_reg[23:0], byte_data_i};
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        // Present address and data together with the strobe in the next cycle,
        // and keep them afterwards so the bus holds its last values.
        if (byte_cnt_reg == 2'd3) begin
          mem_data_reg <= {word_reg[23:0], byte_data_i};
          mem_addr_reg <= {{(30-IDX_W){1'b0}}, word_idx_reg, 2'b00};
        end
      end

      if ((state_reg == WRITE) && !last_word) begin
        word_idx_reg <= word_idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int DEPTH = 32;
  localparam int LEN_W = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic             byte_valid_i = 1'b0;
  logic [7:0]       byte_data_i = '0;
  logic             byte_ready_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic             cpu_rst_o;
  logic             busy_o;
  logic             done_o;

  instr_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Rising-edge counter, read only on falling edges.
  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_edge_q[$];
  int          acc_q[$];      // edge at which each word's 4th byte is taken
  logic [7:0]  stim[$];

  // Write monitor: a strobe seen after edge E is "high during cycle E+1".
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
      wr_edge_q.push_back(edge_cnt);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  {31'b0, byte_ready_o}, 32'd0);
    check({tag, "_we"},     {31'b0, mem_we_o},     32'd0);
    check({tag, "_addr"},   mem_addr_o,            32'd0);
    check({tag, "_data"},   mem_data_o,            32'd0);
    check({tag, "_cpurst"}, {31'b0, cpu_rst_o},    32'd0);
    check({tag, "_busy"},   {31'b0, busy_o},       32'd0);
    check({tag, "_done"},   {31'b0, done_o},       32'd0);
  endtask

  task automatic start_load(input int len_in);
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = LEN_W'(len_in);
    @(negedge clk_i);
    start_i = 1'b0;
    if (len_in != 0) begin
      check("start_busy",   {31'b0, busy_o},    32'd1);
      check("start_cpurst", {31'b0, cpu_rst_o}, 32'd0);
    end else begin
      check("zero_done", {31'b0, done_o}, 32'd1);
      check("zero_busy", {31'b0, busy_o}, 32'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit fourth);
    int t;
    repeat (gap) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    t = 0;
    while (!byte_ready_o && t < 100) begin
      byte_valid_i = 1'b0;
      @(negedge clk_i);
      t++;
    end
    if (!byte_ready_o) check("ready_wait", {31'b0, byte_ready_o}, 32'd1);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    if (fourth) acc_q.push_back(edge_cnt + 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done_o && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    check("done", {31'b0, done_o}, 32'd1);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_edge_q.delete();
    acc_q.delete();
  endtask

  // One complete load checked against the expected write list:
  // word i of min(len, DEPTH) goes to address 4*i, bytes packed big-endian.
  task automatic run_load(input int len_in, input int max_gap, input bit mid_start, input bit fixed);
    int n;
    int nb;
    logic [31:0] exp_word;
    n  = (len_in > DEPTH) ? DEPTH : len_in;
    nb = n * 4;
    if (!fixed) begin
      stim.delete();
      for (int k = 0; k < nb; k++) stim.push_back(8'($urandom));
    end
    clear_log();
    start_load(len_in);
    for (int k = 0; k < nb; k++) begin
      send_byte(stim[k], int'($urandom_range(0, max_gap)), (k % 4) == 3);
      if (mid_start && k == 1) begin
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        len_i        = LEN_W'(5);
        @(negedge clk_i);
        start_i = 1'b0;
      end
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    wait_done();
    check("wr_count", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      exp_word = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
      check("wr_addr", wr_addr_q[i], 32'(i * 4));
      check("wr_data", wr_data_q[i], exp_word);
      if (i < acc_q.size()) check("wr_latency", 32'(wr_edge_q[i]), 32'(acc_q[i]));
    end
    if (n > 0) begin
      exp_word = {stim[nb-4], stim[nb-3], stim[nb-2], stim[nb-1]};
      check("hold_addr", mem_addr_o, 32'((n - 1) * 4));
      check("hold_data", mem_data_o, exp_word);
    end
    check("end_cpurst", {31'b0, cpu_rst_o}, 32'd1);
    check("end_busy",   {31'b0, busy_o},    32'd0);
    $display("load len_i=%0d words=%0d writes=%0d gap<=%0d", len_in, n, wr_addr_q.size(), max_gap);
  endtask

  initial begin
    // Power-on reset: outputs must clear without any clock edge.
    #1 rst_i = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("idle");

    // Basic two-word load, fixed bytes.
    stim.delete();
    stim.push_back(8'h20); stim.push_back(8'h11); stim.push_back(8'h00); stim.push_back(8'h05);
    stim.push_back(8'h8C); stim.push_back(8'h01); stim.push_back(8'h00); stim.push_back(8'h04);
    run_load(2, 0, 1'b0, 1'b1);
    if (wr_data_q.size() == 2) begin
      check("basic_w0", wr_data_q[0], 32'h2011_0005);
      check("basic_w1", wr_data_q[1], 32'h8C01_0004);
    end

    // One word with one-cycle gaps between bytes.
    stim.delete();
    for (int k = 0; k < 4; k++) stim.push_back(8'($urandom));
    clear_log();
    start_load(1);
    for (int k = 0; k < 4; k++) send_byte(stim[k], 1, k == 3);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    wait_done();
    check("stall_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("stall_data", wr_data_q[0], {stim[0], stim[1], stim[2], stim[3]});
      check("stall_latency", 32'(wr_edge_q[0]), 32'(acc_q[0]));
    end
    $display("load len_i=1 stalled writes=%0d", wr_addr_q.size());

    // Zero length, then clipped oversize length.
    run_load(0, 0, 1'b0, 1'b0);
    run_load(40, 1, 1'b0, 1'b0);
    if (wr_addr_q.size() > 0) check("clip_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'h7C);

    // start_i during RECV must not change the captured length.
    run_load(1, 0, 1'b1, 1'b0);

    // Random reloads from DONE, each must restart at address 0.
    for (int r = 0; r < 4; r++) run_load(int'($urandom_range(1, 6)), 2, 1'b0, 1'b0);
    run_load(int'($urandom_range(0, 63)), 1, 1'b0, 1'b0);

    // Reset in the middle of word 1.
    stim.delete();
    for (int k = 0; k < 12; k++) stim.push_back(8'($urandom));
    clear_log();
    start_load(3);
    for (int k = 0; k < 6; k++) send_byte(stim[k], 0, (k % 4) == 3);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 check_all_zero("midrst");
    clear_log();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (8) begin
      @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    check("postrst_writes", 32'(wr_addr_q.size()), 32'd0);
    check("postrst_busy",   {31'b0, busy_o},       32'd0);
    check("postrst_done",   {31'b0, done_o},       32'd0);
    check("postrst_ready",  {31'b0, byte_ready_o}, 32'd0);
    $display("mid-load reset: writes after release=%0d", wr_addr_q.size());
    run_load(2, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
